mc_ctrl_fsm: RTL and testbench

//  Multi-cycle main controller: drives the PC-update interface (pc_en, pc_select) and the datapath enables.

---
 rtl/mc_ctrl_fsm_pkg.sv | 70 +++++++
 rtl/mc_main_dec.sv | 30 +++
 rtl/mc_ctrl_fsm.sv | 162 ++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: shared encodings for the multi-cycle controller and its
// datapath muxes: opcode/funct constants, state codes, instruction classes,
// mux-select encodings and the control-word struct driven by the controller.
package mc_ctrl_fsm_pkg;

  // opcode (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // funct (IR[5:0]) for R-type
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    IC_RTYPE_ALU, IC_JR, IC_ORI, IC_LUI, IC_LW,
    IC_SW, IC_BEQ, IC_J, IC_JAL, IC_ILLEGAL
  } iclass_t;

  localparam logic [1:0] PCS_SEQ  = 2'b00;
  localparam logic [1:0] PCS_BR   = 2'b01;
  localparam logic [1:0] PCS_JMP  = 2'b10;
  localparam logic [1:0] PCS_JR   = 2'b11;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI16 = 2'b10;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  typedef struct packed {
    logic       ir_wr;
    logic       pc_en;
    logic [1:0] pc_select;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic       mem_wr;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_main_dec.sv
// mc_main_dec: combinational opcode/funct -> instruction class.
// Ports: opcode[5:0], funct[5:0] in; iclass out. Anything not decoded
// (including unknown R-type funct codes) maps to IC_ILLEGAL.
module mc_main_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass
);

  always_comb begin
    iclass = IC_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU || funct == FN_SUBU) iclass = IC_RTYPE_ALU;
        else if (funct == FN_JR)                  iclass = IC_JR;
      end
      OP_ORI:  iclass = IC_ORI;
      OP_LUI:  iclass = IC_LUI;
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      OP_BEQ:  iclass = IC_BEQ;
      OP_J:    iclass = IC_J;
      OP_JAL:  iclass = IC_JAL;
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS-lite main controller. Walks each instruction
// through FETCH/DECODE/EXE/MEM/WB and strobes pc_en once, in its last cycle.
// Ports: clk, reset (sync, active-high); opcode/funct from the IR;
// ir_wr, pc_en, pc_select, reg_wr, reg_dst, wb_sel, alu_src, alu_op, ext_op,
// mem_wr, illegal control outputs; state (debug); instr_cnt/cycle_cnt.
// Build option: define MC_PERF_EN to build the retired-instruction and cycle
// counters; otherwise both counter outputs are tied to 0.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic             ir_wr,
  output logic             pc_en,
  output logic [1:0]       pc_select,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             mem_wr,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_t  st_q, st_nxt;
  iclass_t ic;
  ctrl_t   c, o;

  mc_main_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .iclass (ic)
  );

  always_ff @(posedge clk) begin
    if (reset) st_q <= S_FETCH;
    else       st_q <= st_nxt;
  end

  always_comb begin
    st_nxt = S_FETCH;
    c      = '0;
    case (st_q)
      S_FETCH: begin
        c.ir_wr = 1'b1;
        st_nxt  = S_DECODE;
      end
      S_DECODE: begin
        case (ic)
          IC_J: begin
            c.pc_en = 1'b1; c.pc_select = PCS_JMP;
          end
          IC_JAL: begin
            c.pc_en  = 1'b1; c.pc_select = PCS_JMP;
            c.reg_wr = 1'b1; c.reg_dst = RD_RA; c.wb_sel = WB_PC4;
          end
          IC_JR: begin
            c.pc_en = 1'b1; c.pc_select = PCS_JR;
          end
          IC_ILLEGAL: begin
            // retired as a nop: advance the PC, write nothing
            c.illegal = 1'b1; c.pc_en = 1'b1; c.pc_select = PCS_SEQ;
          end
          default: st_nxt = S_EXE;
        endcase
      end
      S_EXE, S_MEM, S_WB: begin
        // ALU/extender selects are held from EXE through WB so a datapath
        // without a result register still sees a stable ALU output.
        case (ic)
          IC_RTYPE_ALU: begin
            c.alu_src = 1'b0;
            c.alu_op  = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
          end
          IC_ORI: begin
            c.alu_src = 1'b1; c.ext_op = EXT_ZERO; c.alu_op = ALU_OR;
          end
          IC_LUI: begin
            c.alu_src = 1'b1; c.ext_op = EXT_HI16; c.alu_op = ALU_LUI;
          end
          IC_LW, IC_SW: begin
            c.alu_src = 1'b1; c.ext_op = EXT_SIGN; c.alu_op = ALU_ADD;
          end
          IC_BEQ: begin
            c.alu_src = 1'b0; c.alu_op = ALU_SUB;
          end
          default: ;
        endcase
        if (st_q == S_EXE) begin
          if (ic == IC_BEQ) begin
            c.pc_en = 1'b1; c.pc_select = PCS_BR;
            st_nxt  = S_FETCH;
          end else if (ic == IC_LW || ic == IC_SW) begin
            st_nxt = S_MEM;
          end else begin
            st_nxt = S_WB;
          end
        end else if (st_q == S_MEM) begin
          if (ic == IC_SW) begin
            c.mem_wr = 1'b1; c.pc_en = 1'b1; c.pc_select = PCS_SEQ;
            st_nxt   = S_FETCH;
          end else begin
            st_nxt = S_WB;
          end
        end else begin
          c.reg_wr    = 1'b1;
          c.pc_en     = 1'b1;
          c.pc_select = PCS_SEQ;
          c.reg_dst   = (ic == IC_RTYPE_ALU) ? RD_RD : RD_RT;
          c.wb_sel    = (ic == IC_LW) ? WB_MEM : WB_ALU;
          st_nxt      = S_FETCH;
        end
      end
      default: st_nxt = S_FETCH; // codes 5-7: recover to FETCH
    endcase
  end

  // Reset is synchronous, so the state register still holds the old state
  // during the reset cycle; force every output low so no write escapes.
  assign o         = reset ? '0 : c;
  assign ir_wr     = o.ir_wr;
  assign pc_en     = o.pc_en;
  assign pc_select = o.pc_select;
  assign reg_wr    = o.reg_wr;
  assign reg_dst   = o.reg_dst;
  assign wb_sel    = o.wb_sel;
  assign alu_src   = o.alu_src;
  assign alu_op    = o.alu_op;
  assign ext_op    = o.ext_op;
  assign mem_wr    = o.mem_wr;
  assign illegal   = o.illegal;
  assign state     = reset ? 3'd0 : st_q;

`ifdef MC_PERF_EN
  logic [CNT_W-1:0] icnt_q, ccnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      icnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      ccnt_q <= ccnt_q + CNT_W'(1);
      if (o.pc_en) icnt_q <= icnt_q + CNT_W'(1);
    end
  end

  assign instr_cnt = icnt_q;
  assign cycle_cnt = ccnt_q;
`else
  assign instr_cnt = '0;
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: self-checking bench for mc_ctrl_fsm. Expected behaviour
// comes from a per-instruction table model (class, latency, which cycle
// carries which strobe); stimulus mixes directed and $urandom instructions.
module tb_mc_ctrl_fsm;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode, funct;
  logic             ir_wr, pc_en, reg_wr, alu_src, mem_wr, illegal;
  logic [1:0]       pc_select, reg_dst, wb_sel, ext_op;
  logic [2:0]       alu_op, state;
  logic [CNT_W-1:0] instr_cnt, cycle_cnt;

  int checks = 0;
  int errors = 0;

  mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .ir_wr(ir_wr), .pc_en(pc_en), .pc_select(pc_select), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
    .ext_op(ext_op), .mem_wr(mem_wr), .illegal(illegal), .state(state),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // classes: 0 addu/subu, 1 jr, 2 ori, 3 lui, 4 lw, 5 sw, 6 beq, 7 j, 8 jal, 9 illegal
  function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b100001 || fn == 6'b100011) return 0;
        if (fn == 6'b001000) return 1;
        return 9;
      end
      6'b001101: return 2;
      6'b001111: return 3;
      6'b100011: return 4;
      6'b101011: return 5;
      6'b000100: return 6;
      6'b000010: return 7;
      6'b000011: return 8;
      default:   return 9;
    endcase
  endfunction

  function automatic int latency(input int cl);
    if (cl == 1 || cl == 7 || cl == 8 || cl == 9) return 2;
    if (cl == 6) return 3;
    if (cl == 4) return 5;
    return 4;
  endfunction

  // state seen in cycle k (1-based) of an instruction
  function automatic logic [2:0] exp_state(input int cl, input int k);
    if (k <= 3) return 3'(k - 1);
    if (k == 4) return (cl == 4 || cl == 5) ? 3'd3 : 3'd4;
    return 3'd4;
  endfunction

  function automatic logic [1:0] exp_sel(input int cl);
    if (cl == 7 || cl == 8) return 2'b10;
    if (cl == 1) return 2'b11;
    if (cl == 6) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle; ends at the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    int cl, lat;
    logic last;
    logic [9:0] got, exp;
    logic       exp_rw;
    cl  = cls(op, fn);
    lat = latency(cl);
    opcode = op;
    funct  = fn;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      last   = (k == lat);
      exp_rw = last && (cl == 0 || cl == 2 || cl == 3 || cl == 4 || cl == 8);
      exp = {exp_state(cl, k), (k == 1), last, last ? exp_sel(cl) : 2'b00,
             exp_rw, last && (cl == 5), last && (cl == 9)};
      got = {state, ir_wr, pc_en, pc_select, reg_wr, mem_wr, illegal};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL instr op=%b fn=%b cyc=%0d {st,ir,pc,sel,rw,mw,ill} got=%b want=%b",
                 op, fn, k, got, exp);
      end
      if (exp_rw) begin
        checks++;
        if ({reg_dst, wb_sel} !== {(cl == 8) ? 2'b10 : (cl == 0) ? 2'b01 : 2'b00,
                                   (cl == 8) ? 2'b10 : (cl == 4) ? 2'b01 : 2'b00}) begin
          errors++;
          $display("FAIL wb_ctrl op=%b {reg_dst,wb_sel} got=%b%b", op, reg_dst, wb_sel);
        end
      end
      if (k == 3) begin
        checks++;
        case (cl)
          0: if ({alu_src, alu_op} !== {1'b0, (fn == 6'b100011) ? 3'b001 : 3'b000}) begin
               errors++; $display("FAIL exe_rtype src/op got=%b/%b", alu_src, alu_op);
             end
          2: if ({alu_src, alu_op, ext_op} !== {1'b1, 3'b010, 2'b00}) begin
               errors++; $display("FAIL exe_ori src/op/ext got=%b/%b/%b", alu_src, alu_op, ext_op);
             end
          3: if (ext_op !== 2'b10) begin
               errors++; $display("FAIL exe_lui ext got=%b want=10", ext_op);
             end
          4, 5: if ({alu_src, alu_op, ext_op} !== {1'b1, 3'b000, 2'b01}) begin
               errors++; $display("FAIL exe_mem src/op/ext got=%b/%b/%b", alu_src, alu_op, ext_op);
             end
          default: if (alu_op !== 3'b001) begin
               errors++; $display("FAIL exe_beq alu_op got=%b want=001", alu_op);
             end
        endcase
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset  = 1'b1;
    opcode = 6'b100011;
    funct  = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ir_wr, pc_en, pc_select, reg_wr, reg_dst, wb_sel, alu_src, alu_op,
           ext_op, mem_wr, illegal, state, instr_cnt, cycle_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d ir=%b pc=%b rw=%b mw=%b st=%0d", i,
                 ir_wr, pc_en, reg_wr, mem_wr, state);
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, ir_wr} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_release state=%0d ir_wr=%b want 0/1", state, ir_wr);
    end
    do_reset();
  endtask

  task automatic test_directed();
    run_instr(6'b100011, 6'b000000); // lw
    run_instr(6'b101011, 6'b000000); // sw
    run_instr(6'b000100, 6'b000000); // beq
    run_instr(6'b000011, 6'b000000); // jal
    run_instr(6'b000000, 6'b001000); // jr
    run_instr(6'b000010, 6'b000000); // j
    run_instr(6'b111111, 6'b000000); // illegal opcode
    run_instr(6'b000000, 6'b111111); // illegal funct
    run_instr(6'b000000, 6'b100001); // addu
    run_instr(6'b000000, 6'b100011); // subu
    run_instr(6'b001101, 6'b010101); // ori
    run_instr(6'b001111, 6'b000000); // lui
  endtask

  task automatic test_sw_reset();
    opcode = 6'b101011;
    funct  = 6'b000000;
    repeat (3) begin @(posedge clk); #1; end // FETCH, DECODE, EXE
    reset = 1'b1;                            // now in MEM
    @(negedge clk);
    checks++;
    if ({mem_wr, pc_en, reg_wr, state} !== 6'b0) begin
      errors++;
      $display("FAIL sw_reset_mem mem_wr=%b pc_en=%b reg_wr=%b state=%0d",
               mem_wr, pc_en, reg_wr, state);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, ir_wr} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL sw_reset_after state=%0d ir_wr=%b want 0/1", state, ir_wr);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [5:0] op, fn;
    ops = '{6'b000000, 6'b001101, 6'b001111, 6'b100011,
            6'b101011, 6'b000100, 6'b000010, 6'b000011};
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        op = ops[$urandom_range(0, 7)];
        case ($urandom_range(0, 3))
          0: fn = 6'b100001;
          1: fn = 6'b100011;
          2: fn = 6'b001000;
          default: fn = 6'($urandom);
        endcase
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr(op, fn);
    end
  endtask

  task automatic test_perf();
    do_reset();
    for (int n = 0; n < 10; n++) run_instr(6'b000000, 6'b100001);
    @(negedge clk);
    checks++;
`ifdef MC_PERF_EN
    if (cycle_cnt !== 32'd40 || instr_cnt !== 32'd10) begin
      errors++;
      $display("FAIL perf_counts cycle_cnt=%0d instr_cnt=%0d want 40/10", cycle_cnt, instr_cnt);
    end
`else
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_tied cycle_cnt=%0d instr_cnt=%0d want 0/0", cycle_cnt, instr_cnt);
    end
`endif
    do_reset();
  endtask

  initial begin
    reset  = 1'b1;
    opcode = '0;
    funct  = '0;
    test_reset();
    test_directed();
    test_sw_reset();
    test_random();
    test_perf();
    run_instr(6'b100011, 6'b000000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
